// File: rtl/cim_write_ctrl.sv
// rtl/cim_write_ctrl.sv - setup/pulse/hold write sequencer for the cim_array write port
module cim_write_ctrl #(
    parameter int DATA_W    = 24,
    parameter int ROWS      = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    parameter int ROW_W     = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_bank,
    input  logic [ROW_W-1:0]  s_row,
    input  logic              clear,
    output logic [DATA_W-1:0] D,
    output logic [ROWS-1:0]   WA0,
    output logic [ROWS-1:0]   WA1,
    output logic              busy,
    output logic              wr_done,
    output logic [ROWS-1:0]   loaded0,
    output logic [ROWS-1:0]   loaded1
);

    // The phase counter must hold the largest per-phase reload value (CYC-1).
    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                bank_q, bank_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [ROWS-1:0]     wa0_q, wa0_d;
    logic [ROWS-1:0]     wa1_q, wa1_d;
    logic                done_q, done_d;
    logic [ROWS-1:0]     loaded0_q, loaded0_d;
    logic [ROWS-1:0]     loaded1_q, loaded1_d;
    logic [ROWS-1:0]     row_onehot;

    assign row_onehot = ROWS'(1) << row_q;

    // Next-state, phase counter, word-line and bitmap updates.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        bank_d    = bank_q;
        row_d     = row_q;
        wa0_d     = wa0_q;
        wa1_d     = wa1_q;
        done_d    = 1'b0;
        // Clear first so a write completing on the same edge still records its bit.
        loaded0_d = clear ? '0 : loaded0_q;
        loaded1_d = clear ? '0 : loaded1_q;

        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    data_d  = s_data;
                    bank_d  = s_bank;
                    row_d   = s_row;
                    cnt_d   = SETUP_LOAD;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LOAD;
                    if (bank_q) begin
                        wa1_d = row_onehot;
                    end else begin
                        wa0_d = row_onehot;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                    wa0_d   = '0;
                    wa1_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    if (bank_q) begin
                        loaded1_d[row_q] = 1'b1;
                    end else begin
                        loaded0_d[row_q] = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                wa0_d   = '0;
                wa1_d   = '0;
            end
        endcase
    end

    // State and output registers; reset drops the word lines without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            bank_q    <= 1'b0;
            row_q     <= '0;
            wa0_q     <= '0;
            wa1_q     <= '0;
            done_q    <= 1'b0;
            loaded0_q <= '0;
            loaded1_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            data_q    <= data_d;
            bank_q    <= bank_d;
            row_q     <= row_d;
            wa0_q     <= wa0_d;
            wa1_q     <= wa1_d;
            done_q    <= done_d;
            loaded0_q <= loaded0_d;
            loaded1_q <= loaded1_d;
        end
    end

    assign s_ready = (state_q == ST_IDLE);
    assign busy    = ~s_ready;
    assign D       = data_q;
    assign WA0     = wa0_q;
    assign WA1     = wa1_q;
    assign wr_done = done_q;
    assign loaded0 = loaded0_q;
    assign loaded1 = loaded1_q;

endmodule
